// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the MEM stage and the data RAM.
// Stores drain to the RAM one per cycle whenever no load holds the shared
// address port. Loads forward data from the youngest queued store to the
// same address, so a load never observes stale RAM contents.
module store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_valid,
    input  logic [AW-1:0]            st_addr,
    input  logic [DW-1:0]            st_data,
    input  logic                     ld_valid,
    input  logic [AW-1:0]            ld_addr,
    output logic [DW-1:0]            ld_data,
    output logic                     ld_fwd,
    output logic                     st_stall,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [AW-1:0]            ram_a,
    output logic [DW-1:0]            ram_wd,
    output logic                     ram_we,
    input  logic [DW-1:0]            ram_rd
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    // Entry storage and bookkeeping
    logic [AW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    rd_ptr_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    // Handshake terms
    logic             empty_w;
    logic             full_w;
    logic             pop;
    logic             push;

    // Forwarding scan temporaries
    logic [PW-1:0]    fwd_idx;
    logic             fwd_hit;
    logic [DW-1:0]    fwd_data;

    // RAM port arbitration and store acceptance: loads always own the port
    always_comb begin
        empty_w  = (count_q == '0);
        full_w   = (count_q == CW'(DEPTH));
        pop      = !empty_w && !ld_valid;
        push     = st_valid && !ld_valid && (!full_w || pop);
        st_stall = st_valid && !push;
        ram_we   = pop;
        ram_a    = ld_valid ? ld_addr : addr_q[rd_ptr_q];
        ram_wd   = data_q[rd_ptr_q];
        empty    = empty_w;
        count    = count_q;
    end

    // Next-state for pointers, valid bits and occupancy; pop is applied
    // before push so a full buffer can recycle the head slot in one cycle
    always_comb begin
        valid_d  = valid_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PW'(1);
        end
        if (push) begin
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // Load forwarding: scan oldest to youngest from rd_ptr so the last hit
    // seen is the youngest matching store
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr_q + PW'(i);
            if (valid_q[fwd_idx] && (addr_q[fwd_idx] == ld_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[fwd_idx];
            end
        end
    end

    // Load result mux: buffered data wins over the RAM read
    always_comb begin
        ld_fwd  = fwd_hit;
        ld_data = fwd_hit ? fwd_data : ram_rd;
    end

    // Control state: reset discards every queued store immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry payload: written on push only, qualified by valid_q elsewhere
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            addr_q[wr_ptr_q] <= st_addr;
            data_q[wr_ptr_q] <= st_data;
        end
    end

endmodule
